multicycle_ctrl: RTL

Control FSM for a multi-cycle version of the MIPS-subset CPU. The datapath uses one shared ALU, one unified instruction/data memory port, and IR, A, B, MDR and aluOut registers. This block sequences each instruction through fetch, decode, execute, memory and writeback by driving every datapath enable and mux select. It replaces the single-cycle combinational decoder for control purposes; field extraction (rs/rt/rd/imm/jAddr) stays in the datapath.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle control FSM and the CPU datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       aluZero;
  logic       aluOverflow;

  logic       pcWe;
  logic       irWe;
  logic       regWe;
  logic       dmWe;
  logic       memAddrSel;
  logic       aluASrc;
  logic [1:0] aluBSrc;
  logic       immZext;
  logic [2:0] aluOp;
  logic [1:0] pcSrc;
  logic [1:0] regWAddrSel;
  logic [1:0] regDInSel;
  logic [3:0] state;
  logic       illegal;
  logic       trap;

  modport master (
    input  opcode, funct, aluZero, aluOverflow,
    output pcWe, irWe, regWe, dmWe, memAddrSel, aluASrc, aluBSrc, immZext,
           aluOp, pcSrc, regWAddrSel, regDInSel, state, illegal, trap
  );

  modport slave (
    output opcode, funct, aluZero, aluOverflow,
    input  pcWe, irWe, regWe, dmWe, memAddrSel, aluASrc, aluBSrc, immZext,
           aluOp, pcSrc, regWAddrSel, regDInSel, state, illegal, trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM driving every datapath enable and mux select.
// Optional macro OVERFLOW_TRAP_EN: halt instead of writing back an overflowed ADD/SUB/ADDI.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OPC_W-1:0] FN_JR  = 6'h08;
  localparam logic [OPC_W-1:0] FN_ADD = 6'h20;
  localparam logic [OPC_W-1:0] FN_SUB = 6'h22;
  localparam logic [OPC_W-1:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_LWWB    = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_IEXEC   = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_UNUSED  = 4'd14,
    S_HALT    = 4'd15
  } state_e;

  state_e state_q, state_d;

  logic       pc_we_c, ir_we_c, reg_we_c, dm_we_c;
  logic       mem_addr_sel_c, alu_a_src_c, imm_zext_c;
  logic [1:0] alu_b_src_c, pc_src_c, reg_waddr_sel_c, reg_din_sel_c;
  logic [2:0] alu_op_c;
  logic       illegal_c, trap_c;

  // Instruction classification from the latched IR fields
  logic is_rtype, is_radd_sub, is_rarith, is_jr, branch_eq;
  assign is_rtype    = (bus.opcode == OP_RTYPE);
  assign is_radd_sub = is_rtype && ((bus.funct == FN_ADD) || (bus.funct == FN_SUB));
  assign is_rarith   = is_radd_sub || (is_rtype && (bus.funct == FN_SLT));
  assign is_jr       = is_rtype && (bus.funct == FN_JR);
  assign branch_eq   = bus.aluZero & ~bus.aluOverflow;

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_we_c         = 1'b0;
    ir_we_c         = 1'b0;
    reg_we_c        = 1'b0;
    dm_we_c         = 1'b0;
    mem_addr_sel_c  = 1'b0;
    alu_a_src_c     = 1'b0;
    alu_b_src_c     = 2'd0;
    imm_zext_c      = 1'b0;
    alu_op_c        = ALU_ADD;
    pc_src_c        = 2'd0;
    reg_waddr_sel_c = 2'd0;
    reg_din_sel_c   = 2'd0;
    illegal_c       = 1'b0;
    trap_c          = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    ovf_d           = ovf_q;
`endif

    unique case (state_q)
      S_FETCH: begin
        ir_we_c     = 1'b1;
        alu_b_src_c = 2'd1;
        pc_we_c     = 1'b1;
        state_d     = S_DECODE;
      end
      // Speculative branch target PC+4+(imm<<2) computed into aluOut
      S_DECODE: begin
        alu_b_src_c = 2'd3;
        if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
          state_d = S_MEMADDR;
        end else if (is_rarith) begin
          state_d = S_REXEC;
        end else if (is_jr) begin
          state_d = S_JR;
        end else if ((bus.opcode == OP_ADDI) || (bus.opcode == OP_XORI)) begin
          state_d = S_IEXEC;
        end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
          state_d = S_BRANCH;
        end else if (bus.opcode == OP_J) begin
          state_d = S_JUMP;
        end else if (bus.opcode == OP_JAL) begin
          state_d = S_JAL;
        end else begin
          state_d = S_HALT;
        end
      end
      S_MEMADDR: begin
        alu_a_src_c = 1'b1;
        alu_b_src_c = 2'd2;
        state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_addr_sel_c = 1'b1;
        state_d        = S_LWWB;
      end
      S_LWWB: begin
        reg_we_c      = 1'b1;
        reg_din_sel_c = 2'd1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        mem_addr_sel_c = 1'b1;
        dm_we_c        = 1'b1;
        state_d        = S_FETCH;
      end
      S_REXEC: begin
        alu_a_src_c = 1'b1;
        if (bus.funct == FN_SUB) begin
          alu_op_c = ALU_SUB;
        end else if (bus.funct == FN_SLT) begin
          alu_op_c = ALU_SLT;
        end
`ifdef OVERFLOW_TRAP_EN
        ovf_d = bus.aluOverflow;
`endif
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_we_c        = 1'b1;
        reg_waddr_sel_c = 2'd1;
        state_d         = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
        if (is_radd_sub && ovf_q) begin
          reg_we_c = 1'b0;
          trap_c   = 1'b1;
          state_d  = S_HALT;
        end
`endif
      end
      S_IEXEC: begin
        alu_a_src_c = 1'b1;
        alu_b_src_c = 2'd2;
        if (bus.opcode == OP_XORI) begin
          alu_op_c   = ALU_XOR;
          imm_zext_c = 1'b1;
        end
`ifdef OVERFLOW_TRAP_EN
        ovf_d = bus.aluOverflow;
`endif
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_we_c = 1'b1;
        state_d  = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
        if ((bus.opcode == OP_ADDI) && ovf_q) begin
          reg_we_c = 1'b0;
          trap_c   = 1'b1;
          state_d  = S_HALT;
        end
`endif
      end
      // Live compare A-B; taken target already sits in aluOut
      S_BRANCH: begin
        alu_a_src_c = 1'b1;
        alu_op_c    = ALU_SUB;
        pc_src_c    = 2'd3;
        pc_we_c     = (bus.opcode == OP_BEQ) ? branch_eq : ~branch_eq;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_we_c  = 1'b1;
        pc_src_c = 2'd1;
        state_d  = S_FETCH;
      end
      // PC still holds PC+4, which is the link value written to $31
      S_JAL: begin
        pc_we_c         = 1'b1;
        pc_src_c        = 2'd1;
        reg_we_c        = 1'b1;
        reg_waddr_sel_c = 2'd2;
        reg_din_sel_c   = 2'd2;
        state_d         = S_FETCH;
      end
      S_JR: begin
        pc_we_c  = 1'b1;
        pc_src_c = 2'd2;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        illegal_c = 1'b1;
        state_d   = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Everything is forced low while reset is asserted
  assign bus.pcWe        = ~reset & pc_we_c;
  assign bus.irWe        = ~reset & ir_we_c;
  assign bus.regWe       = ~reset & reg_we_c;
  assign bus.dmWe        = ~reset & dm_we_c;
  assign bus.memAddrSel  = ~reset & mem_addr_sel_c;
  assign bus.aluASrc     = ~reset & alu_a_src_c;
  assign bus.aluBSrc     = reset ? 2'd0 : alu_b_src_c;
  assign bus.immZext     = ~reset & imm_zext_c;
  assign bus.aluOp       = reset ? 3'd0 : alu_op_c;
  assign bus.pcSrc       = reset ? 2'd0 : pc_src_c;
  assign bus.regWAddrSel = reset ? 2'd0 : reg_waddr_sel_c;
  assign bus.regDInSel   = reset ? 2'd0 : reg_din_sel_c;
  assign bus.state       = reset ? 4'd0 : state_q;
  assign bus.illegal     = ~reset & illegal_c;
  assign bus.trap        = ~reset & trap_c;

endmodule
